// File: rtl/dl266_pkg.sv
// Shared defaults, position FSM states and bundle types
// for the dl266 sprite fetch stage.
package dl266_pkg;

    localparam int SPR_W_DEF  = 32;
    localparam int SPR_H_DEF  = 32;
    localparam int ROM_AW_DEF = 10;

    localparam logic [5:0] TRANSP_IDX_DEF = 6'd0;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pos_state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

endpackage

// File: rtl/dl266_pos_shadow.sv
// Sprite position shadow: CPU writes land in a shadow copy
// and reach the active position only at frame start.
module dl266_pos_shadow
    import dl266_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic pos_wr,
    input  pos_t pos_in,
    output pos_t act
);

    pos_state_e state, state_n;
    pos_t       shadow, shadow_n;
    pos_t       act_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            act    <= '0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            act    <= act_n;
        end
    end

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        act_n    = act;
        unique case (state)
            IDLE: begin
                // a write in the blanking pulse itself takes effect now
                if (pos_wr && frame_start) begin
                    act_n = pos_in;
                end else if (pos_wr) begin
                    shadow_n = pos_in;
                    state_n  = PENDING;
                end
            end
            PENDING: begin
                if (pos_wr && frame_start) begin
                    act_n   = pos_in;
                    state_n = IDLE;
                end else if (pos_wr) begin
                    shadow_n = pos_in;
                end else if (frame_start) begin
                    act_n   = shadow;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/dl266_sprite_fetch.sv
// Sprite fetch stage: hit test, ROM address generation and
// transparency masking with a fixed three-cycle latency.
module dl266_sprite_fetch
    import dl266_pkg::*;
#(
    parameter int         SPR_W      = SPR_W_DEF,
    parameter int         SPR_H      = SPR_H_DEF,
    parameter int         ROM_AW     = ROM_AW_DEF,
    parameter logic [5:0] TRANSP_IDX = TRANSP_IDX_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              de,
    input  logic              frame_start,
    input  logic [9:0]        pos_x_in,
    input  logic [9:0]        pos_y_in,
    input  logic              pos_wr,
    input  logic              flip_h,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [5:0]        rom_q,
    output logic [5:0]        index,
    output logic              pix_valid,
    output logic              de_out
);

    localparam logic [10:0] W11 = 11'(SPR_W);
    localparam logic [10:0] H11 = 11'(SPR_H);

    pos_t act;
    pos_t pos_in;

    assign pos_in = '{x: pos_x_in, y: pos_y_in};

    dl266_pos_shadow u_pos (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .frame_start(frame_start),
        .pos_wr     (pos_wr),
        .pos_in     (pos_in),
        .act        (act)
    );

    // 11-bit compare so a sprite near column 1023 cannot wrap to 0
    logic [10:0] dx, dy, ax, ay;
    logic        in_x, in_y, hit;

    assign dx   = {1'b0, draw_x};
    assign dy   = {1'b0, draw_y};
    assign ax   = {1'b0, act.x};
    assign ay   = {1'b0, act.y};
    assign in_x = (dx >= ax) && (dx < ax + W11);
    assign in_y = (dy >= ay) && (dy < ay + H11);
    assign hit  = de && in_x && in_y;

    logic [9:0]        ox, oy, oxf;
    logic [ROM_AW-1:0] addr_n;

    assign ox     = draw_x - act.x;
    assign oy     = draw_y - act.y;
    assign oxf    = flip_h ? (10'(SPR_W - 1) - ox) : ox;
    assign addr_n = ROM_AW'(oy) * ROM_AW'(SPR_W) + ROM_AW'(oxf);

    logic hit_d1, hit_d2;
    logic de_d1, de_d2;
    logic opaque;

    assign opaque = hit_d2 && (rom_q != TRANSP_IDX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            hit_d2    <= 1'b0;
            de_d1     <= 1'b0;
            de_d2     <= 1'b0;
            index     <= '0;
            pix_valid <= 1'b0;
            de_out    <= 1'b0;
        end else begin
            if (hit) begin
                rom_addr <= addr_n;
            end
            hit_d1    <= hit;
            hit_d2    <= hit_d1;
            de_d1     <= de;
            de_d2     <= de_d1;
            de_out    <= de_d2;
            pix_valid <= opaque;
            index     <= opaque ? rom_q : 6'd0;
        end
    end

endmodule

// File: tb/tb_dl266_sprite_fetch.sv
// Self-checking bench for dl266_sprite_fetch with a
// synchronous sprite ROM model and a pixel-level reference.
module tb_dl266_sprite_fetch;

    localparam int SPR_W = 32;
    localparam int SPR_H = 32;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;
    logic       de = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] pos_x_in = '0;
    logic [9:0] pos_y_in = '0;
    logic       pos_wr = 1'b0;
    logic       flip_h = 1'b0;
    logic [9:0] rom_addr;
    logic [5:0] rom_q = '0;
    logic [5:0] index;
    logic       pix_valid;
    logic       de_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    dl266_sprite_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .de         (de),
        .frame_start(frame_start),
        .pos_x_in   (pos_x_in),
        .pos_y_in   (pos_y_in),
        .pos_wr     (pos_wr),
        .flip_h     (flip_h),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .index      (index),
        .pix_valid  (pix_valid),
        .de_out     (de_out)
    );

    always #5 Clk = ~Clk;

    function automatic int rom_fn(int a);
        return (a & 63) ^ 5;
    endfunction

    always @(posedge Clk) rom_q <= 6'(rom_fn(int'(rom_addr)));

    // reference: sprite rectangle test and pixel address in plain integers
    function automatic bit f_hit(int x, int y, bit d, int ax, int ay);
        return d && x >= ax && x < ax + SPR_W && y >= ay && y < ay + SPR_H;
    endfunction

    function automatic int f_addr(int x, int y, int ax, int ay, bit fl);
        int ox, oy;
        ox = x - ax;
        oy = y - ay;
        if (fl) ox = SPR_W - 1 - ox;
        return (oy * SPR_W + ox) & 1023;
    endfunction

    typedef struct {
        bit hit;
        bit de;
        int a;
    } stg_t;

    stg_t e1 = '{0, 0, 0};
    stg_t e2 = '{0, 0, 0};
    stg_t e3 = '{0, 0, 0};
    int   m_ax = 0, m_ay = 0, m_sx = 0, m_sy = 0, m_addr = 0;
    bit   m_pend = 0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_ax   <= 0;
            m_ay   <= 0;
            m_sx   <= 0;
            m_sy   <= 0;
            m_pend <= 0;
            m_addr <= 0;
            e1     <= '{0, 0, 0};
            e2     <= '{0, 0, 0};
            e3     <= '{0, 0, 0};
        end else begin
            e1 <= '{f_hit(draw_x, draw_y, de, m_ax, m_ay), de,
                    f_hit(draw_x, draw_y, de, m_ax, m_ay) ?
                    f_addr(draw_x, draw_y, m_ax, m_ay, flip_h) : m_addr};
            e2 <= e1;
            e3 <= e2;
            if (f_hit(draw_x, draw_y, de, m_ax, m_ay))
                m_addr <= f_addr(draw_x, draw_y, m_ax, m_ay, flip_h);
            if (pos_wr && frame_start) begin
                m_ax   <= pos_x_in;
                m_ay   <= pos_y_in;
                m_pend <= 0;
            end else if (pos_wr) begin
                m_sx   <= pos_x_in;
                m_sy   <= pos_y_in;
                m_pend <= 1;
            end else if (frame_start && m_pend) begin
                m_ax   <= m_sx;
                m_ay   <= m_sy;
                m_pend <= 0;
            end
        end
    end

    task automatic chk(string n, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    function automatic int exp_idx(stg_t s);
        return (s.hit && rom_fn(s.a) != 0) ? rom_fn(s.a) : 0;
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model rom_addr", int'(rom_addr), m_addr);
            chk("model index", int'(index), exp_idx(e3));
            chk("model pix_valid", int'(pix_valid), int'(exp_idx(e3) != 0));
            chk("model de_out", int'(de_out), int'(e3.de));
        end
    end

    task automatic setpos(int x, int y, bit wr, bit fs);
        @(negedge Clk);
        pos_x_in    = 10'(x);
        pos_y_in    = 10'(y);
        pos_wr      = wr;
        frame_start = fs;
        @(negedge Clk);
        pos_wr      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic probe(string n, int x, int y, bit d, bit fl,
                         int ea, int ei, bit ep, bit ed);
        @(negedge Clk);
        draw_x = 10'(x);
        draw_y = 10'(y);
        de     = d;
        flip_h = fl;
        @(negedge Clk);
        de     = 1'b0;
        flip_h = 1'b0;
        chk({n, " rom_addr"}, int'(rom_addr), ea);
        @(negedge Clk);
        @(negedge Clk);
        chk({n, " index"}, int'(index), ei);
        chk({n, " pix_valid"}, int'(pix_valid), int'(ep));
        chk({n, " de_out"}, int'(de_out), int'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 Reset_n = 1'b0;
        #1;
        chk("reset rom_addr", int'(rom_addr), 0);
        chk("reset index", int'(index), 0);
        chk("reset pix_valid", int'(pix_valid), 0);
        chk("reset de_out", int'(de_out), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        chk_en  = 1'b1;

        setpos(100, 50, 1, 1);
        probe("origin", 100, 50, 1, 0, 0, 5, 1, 1);
        probe("corner flip", 131, 81, 1, 1, 992, 37, 1, 1);
        probe("corner", 131, 81, 1, 0, 1023, 58, 1, 1);
        probe("right miss", 132, 81, 1, 0, 1023, 0, 0, 1);
        probe("transparent", 105, 50, 1, 0, 5, 0, 0, 1);

        setpos(200, 10, 1, 0);
        setpos(300, 20, 1, 0);
        probe("old pos held", 100, 50, 1, 0, 0, 5, 1, 1);
        probe("new pos early", 300, 20, 1, 0, 0, 0, 0, 1);
        setpos(0, 0, 0, 1);
        probe("new pos live", 300, 20, 1, 0, 0, 5, 1, 1);
        probe("old pos gone", 100, 50, 1, 0, 0, 0, 0, 1);
        setpos(5, 5, 1, 1);
        probe("coincident", 5, 5, 1, 0, 0, 5, 1, 1);
        probe("coincident +1", 6, 6, 1, 0, 33, 36, 1, 1);
        setpos(0, 0, 0, 1);
        probe("idle fs", 6, 6, 1, 0, 33, 36, 1, 1);

        setpos(620, 470, 1, 1);
        probe("clip corner", 639, 479, 1, 0, 307, 54, 1, 1);
        probe("blank col", 640, 479, 0, 0, 307, 0, 0, 0);
        setpos(1000, 0, 1, 1);
        probe("no wrap", 5, 0, 1, 0, 307, 0, 0, 1);
        probe("edge 1023", 1023, 0, 1, 0, 23, 18, 1, 1);

        setpos(50, 60, 1, 0);
        @(negedge Clk);
        draw_x = 10'd1001;
        draw_y = 10'd0;
        de     = 1'b1;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("midreset rom_addr", int'(rom_addr), 0);
        chk("midreset index", int'(index), 0);
        chk("midreset pix_valid", int'(pix_valid), 0);
        chk("midreset de_out", int'(de_out), 0);
        @(negedge Clk);
        de = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        setpos(0, 0, 0, 1);
        probe("pending lost", 50, 60, 1, 0, 0, 0, 0, 1);
        probe("post reset", 0, 0, 1, 0, 0, 5, 1, 1);
        probe("post reset far", 31, 31, 1, 0, 1023, 58, 1, 1);

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl266_sprite_fetch.md
DL266_SPRITE_FETCH -- requirements
Module: dl266_sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 32, sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPR_H, default 32, sprite height in pixels.
REQ-003 SHALL have parameter ROM_AW, default 10, sprite ROM address width (2^ROM_AW >= SPR_W*SPR_H).
REQ-004 SHALL have parameter TRANSP_IDX, default 6'd0, palette index treated as transparent.
REQ-005 SHALL have ports: Clk  in  1  sole clock; Reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: draw_x  in  10  current scan column; draw_y  in  10  current scan row; de  in  1  display enable.
REQ-007 SHALL have ports: frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-008 SHALL have ports: pos_x_in  in  10, pos_y_in  in  10  requested sprite top-left; pos_wr  in  1  position-write strobe; flip_h  in  1  horizontal mirror.
REQ-009 SHALL have ports: rom_addr  out  ROM_AW  sprite ROM address; rom_q  in  6  ROM data, valid one cycle after rom_addr.
REQ-010 SHALL have ports: index  out  6  palette index to the palette stage; pix_valid  out  1  opaque sprite pixel; de_out  out  1  de delayed to align with index.

Function
REQ-011 SHALL sample draw_x/draw_y/de in cycle N, drive rom_addr registered in N+1, and drive index/pix_valid/de_out registered in N+3 (fixed latency 3).
REQ-012 SHALL compute hit = de AND act_x <= draw_x < act_x+SPR_W AND act_y <= draw_y < act_y+SPR_H using 11-bit arithmetic (no wrap at 1023).
REQ-013 SHALL form ox = draw_x-act_x, oy = draw_y-act_y; with flip_h (sampled in cycle N) ox' = SPR_W-1-ox, else ox' = ox.
REQ-014 SHALL set rom_addr = oy*SPR_W + ox' truncated to ROM_AW when hit, else hold previous rom_addr.
REQ-015 SHALL pipeline hit alongside the address; index = rom_q and pix_valid = 1 only if delayed hit = 1 and rom_q != TRANSP_IDX.
REQ-016 SHALL drive index = 0 and pix_valid = 0 whenever delayed hit = 0 or rom_q == TRANSP_IDX.
REQ-017 SHALL hold active position act_x/act_y constant during a frame; updates apply only on frame_start.
REQ-018 SHALL implement position FSM: IDLE --pos_wr--> PENDING (capture pos_x_in/pos_y_in into shadow); PENDING --pos_wr--> PENDING (overwrite shadow, last write wins); PENDING --frame_start--> IDLE (act <= shadow).
REQ-019 SHALL, when pos_wr and frame_start coincide, load act directly from pos_x_in/pos_y_in and go to IDLE.
REQ-020 SHALL ignore frame_start in IDLE (act unchanged).
REQ-021 SHALL clip sprites extending past column 639 / row 479 naturally (no hit outside de); no special case.

Reset
REQ-022 SHALL, on Reset_n low, asynchronously clear: act_x, act_y, shadow to 0; FSM to IDLE; rom_addr to 0; all pipeline hit/de stages to 0; index 0, pix_valid 0, de_out 0.
REQ-023 SHALL discard any pending position and in-flight pixels on reset mid-frame; first valid output appears 3 cycles after first sampled hit after release.

Structure
REQ-024 SHALL take SPR_W/SPR_H/ROM_AW/TRANSP_IDX defaults and the FSM state enum (IDLE, PENDING) from shared package dl266_pkg.
REQ-025 SHALL contain one sub-module dl266_pos_shadow implementing REQ-017..REQ-020; ROM stays external.

Verification
REQ-026 act=(100,50), draw=(100,50), de=1, rom_q=6'd5 -> rom_addr=0 at N+1, index=5, pix_valid=1, de_out=1 at N+3.
REQ-027 act=(100,50), draw=(131,81), flip_h=1 -> rom_addr=31*32+0=992; flip_h=0 -> 1023; draw=(132,81) -> pix_valid=0.
REQ-028 hit pixel with rom_q=TRANSP_IDX=0 -> index=0, pix_valid=0, de_out=1.
REQ-029 pos_wr (200,10) then pos_wr (300,20) mid-frame -> act unchanged until frame_start; then act=(300,20); pos_wr (5,5) coincident with frame_start -> act=(5,5).
REQ-030 act=(620,470), draw=(639,479) -> hit, rom_addr=9*32+19=307; draw_x=640 with de=0 -> pix_valid=0.
REQ-031 Reset_n low mid-frame while PENDING -> all outputs 0 immediately, act=(0,0), pending shadow lost after release.
